// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data memory access controller with alignment checks and a bus timeout.
// Ports:
//   clk, reset (async, active-low)
//   mem_valid/opcode/addr/wdata : MEM-stage request, held until done
//   stall                       : pipeline freeze (mem_valid & ~done)
//   done/rdata/exc/exc_code     : completion pulse, extended load data, exception report
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata/dm_ack/dm_rdata : data memory handshake
module dm_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t        r_state;
    logic [3:0]    r_op;
    logic [1:0]    r_lane;
    logic [CW-1:0] r_cnt;
    logic          w_load, w_store, w_sup, w_align;
    logic [3:0]    w_be;
    logic [31:0]   w_wd, w_sh, w_ld;
    logic [7:0]    w_b;
    logic [15:0]   w_h;
    // opcode[5:3] selects load/store, opcode[2] unsigned, opcode[1:0] size (00 byte, 01 half, 11 word)
    assign w_load  = opcode[5:3] == 3'b100;
    assign w_store = opcode[5:3] == 3'b101;
    assign w_sup   = (w_load && (opcode[2] ? !opcode[1] : opcode[1:0] != 2'b10)) ||
                     (w_store && !opcode[2] && opcode[1:0] != 2'b10);
    assign w_align = opcode[1:0] == 2'b00 || (opcode[1:0] == 2'b01 ? !addr[0] : addr[1:0] == 2'b00);
    assign w_be    = !w_store ? 4'hF :
                     opcode[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                     opcode[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
    assign w_wd    = opcode[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     opcode[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    // load extraction uses the latched opcode and byte lane
    assign w_sh    = dm_rdata >> {r_lane, 3'b000};
    assign w_b     = w_sh[7:0];
    assign w_h     = r_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    assign w_ld    = r_op[1:0] == 2'b00 ? {{24{!r_op[2] && w_b[7]}}, w_b} :
                     r_op[1:0] == 2'b01 ? {{16{!r_op[2] && w_h[15]}}, w_h} : dm_rdata;
    assign stall   = mem_valid & ~done;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_lane   <= '0;
            r_cnt    <= '0;
            done     <= 1'b0;
            rdata    <= '0;
            exc      <= 1'b0;
            exc_code <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (mem_valid) begin
                    if (!w_sup) begin
                        r_state  <= RESP;
                        done     <= 1'b1;
                        exc      <= 1'b0;
                        exc_code <= 5'd0;
                    end else if (!w_align) begin
                        r_state  <= RESP;
                        done     <= 1'b1;
                        exc      <= 1'b1;
                        exc_code <= w_store ? 5'd5 : 5'd4;
                    end else begin
                        r_state  <= ACCESS;
                        r_op     <= opcode[3:0];
                        r_lane   <= addr[1:0];
                        r_cnt    <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= w_store;
                        dm_be    <= w_be;
                        dm_addr  <= {addr[31:2], 2'b00};
                        dm_wdata <= w_wd;
                    end
                end
                ACCESS: begin
                    // an ack arriving on the final timeout cycle still completes normally
                    if (dm_ack || r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state  <= RESP;
                        done     <= 1'b1;
                        dm_req   <= 1'b0;
                        dm_we    <= 1'b0;
                        dm_be    <= '0;
                        exc      <= !dm_ack;
                        exc_code <= dm_ack ? 5'd0 : 5'd7;
                        if (dm_ack && !r_op[3]) rdata <= w_ld;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: randomized and directed checks of dm_access_ctrl against a byte-level reference model.
module tb_dm_access_ctrl;
    localparam int TO = 4;
    logic        clk = 0, reset = 0, mem_valid = 0, dm_ack = 0;
    logic [5:0]  opcode = 0;
    logic [31:0] addr = 0, wdata = 0, dm_rdata = 0;
    logic        stall, done, exc, dm_req, dm_we;
    logic [31:0] rdata, dm_addr, dm_wdata;
    logic [4:0]  exc_code;
    logic [3:0]  dm_be;
    int total = 0, bad = 0;

    dm_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .opcode(opcode), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .exc(exc),
        .exc_code(exc_code), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int          obs_done_cyc, obs_req_cyc;
    logic        obs_we, obs_exc, obs_stall_ok;
    logic [3:0]  obs_be;
    logic [5:0]  obs_after;
    logic [31:0] obs_addr, obs_wd, obs_rdata;
    logic [4:0]  obs_code;

    int          exp_done_cyc, exp_req_cyc;
    logic        exp_access, exp_we, exp_exc;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [4:0]  exp_code;

    // Reference: size table, address modulo size, byte replication and shift/mask extension
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits);
        int sz = 0;
        bit ld = 0, st = 0, sgn = 0;
        logic [31:0] v, mask;
        case (op)
            6'b100000: begin sz = 1; ld = 1; sgn = 1; end
            6'b100001: begin sz = 2; ld = 1; sgn = 1; end
            6'b100011: begin sz = 4; ld = 1; end
            6'b100100: begin sz = 1; ld = 1; end
            6'b100101: begin sz = 2; ld = 1; end
            6'b101000: begin sz = 1; st = 1; end
            6'b101001: begin sz = 2; st = 1; end
            6'b101011: begin sz = 4; st = 1; end
            default: sz = 0;
        endcase
        exp_access = 0; exp_req_cyc = 0; exp_done_cyc = 1; exp_exc = 0; exp_code = 0;
        if (sz != 0 && (a % sz) != 0) begin
            exp_exc = 1; exp_code = st ? 5'd5 : 5'd4;
        end else if (sz != 0) begin
            exp_access = 1;
            exp_addr = a - (a % 4);
            exp_we = st;
            exp_be = st ? 4'(((1 << sz) - 1) << (a % 4)) : 4'hF;
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
            if (waits < 0 || waits >= TO) begin
                exp_req_cyc = TO; exp_done_cyc = TO + 1; exp_exc = 1; exp_code = 5'd7;
            end else begin
                exp_req_cyc = waits + 1; exp_done_cyc = waits + 2;
                if (ld) begin
                    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
                    v = (rd >> (8 * (a % 4))) & mask;
                    if (sgn && v[8*sz-1]) v = v | ~mask;
                    exp_rdata = v;
                end
            end
        end
    endtask

    // Drives one request; ack is given once dm_req has been seen 'waits' times before (waits<0: never)
    task automatic txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits);
        model(op, a, wd, rd, waits);
        @(posedge clk); #1;
        mem_valid = 1; opcode = op; addr = a; wdata = wd; dm_rdata = rd; dm_ack = 0;
        obs_done_cyc = -1; obs_req_cyc = 0; obs_stall_ok = 1;
        obs_be = 0; obs_we = 0; obs_addr = 0; obs_wd = 0;
        for (int k = 0; k < 30; k++) begin
            dm_ack = dm_req && (obs_req_cyc == waits);
            @(negedge clk);
            if (dm_req) begin
                if (obs_req_cyc == 0) begin
                    obs_be = dm_be; obs_we = dm_we; obs_addr = dm_addr; obs_wd = dm_wdata;
                end
                obs_req_cyc++;
            end
            if (stall !== !done) obs_stall_ok = 0;
            if (done) begin
                obs_done_cyc = k; obs_rdata = rdata; obs_exc = exc; obs_code = exc_code;
                obs_after = {dm_req, dm_we, dm_be};
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_valid = 0; dm_ack = 0;
    endtask

    task automatic test_reset;
        reset = 0; mem_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({done, rdata, exc, exc_code, dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== '0) begin
            bad++; $display("FAIL reset_outputs: got done=%b rdata=%h exc=%b code=%0d req=%b be=%h, want all zero",
                            done, rdata, exc, exc_code, dm_req, dm_be);
        end
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_hi: got %b want 1", stall); end
        mem_valid = 0; #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_lo: got %b want 0", stall); end
        reset = 1;
        exp_rdata = 0;
    endtask

    task automatic test_lb;
        txn(6'b100000, 32'h1003, 32'h0, 32'h80FF_1234, 0);
        total++;
        if (obs_be !== 4'hF) begin bad++; $display("FAIL lb_be: got %h want f", obs_be); end
        total++;
        if (obs_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
        total++;
        if (obs_done_cyc !== 2) begin bad++; $display("FAIL lb_latency: got %0d want 2", obs_done_cyc); end
        total++;
        if (obs_we !== 1'b0 || obs_addr !== 32'h1000) begin
            bad++; $display("FAIL lb_we_addr: got we=%b addr=%h want we=0 addr=00001000", obs_we, obs_addr);
        end
    endtask

    task automatic test_lhu_wait;
        txn(6'b100101, 32'h2002, 32'h0, 32'h9ABC_0000, 3);
        total++;
        if (obs_rdata !== 32'h0000_9ABC) begin bad++; $display("FAIL lhu_rdata: got %h want 00009abc", obs_rdata); end
        total++;
        if (obs_done_cyc !== 5) begin bad++; $display("FAIL lhu_latency: got %0d want 5", obs_done_cyc); end
        total++;
        if (!obs_stall_ok) begin bad++; $display("FAIL lhu_stall: got stall!=~done in some cycle want stall=~done"); end
        total++;
        if (obs_req_cyc !== 4) begin bad++; $display("FAIL lhu_req_cycles: got %0d want 4", obs_req_cyc); end
    endtask

    task automatic test_sb;
        txn(6'b101000, 32'h10, 32'h55, 32'h0, 0);
        total++;
        if (obs_we !== 1'b1 || obs_be !== 4'b0001) begin
            bad++; $display("FAIL sb_we_be: got we=%b be=%b want we=1 be=0001", obs_we, obs_be);
        end
        total++;
        if (obs_wd !== 32'h5555_5555) begin bad++; $display("FAIL sb_wdata: got %h want 55555555", obs_wd); end
        total++;
        if (obs_addr !== 32'h10) begin bad++; $display("FAIL sb_addr: got %h want 00000010", obs_addr); end
        total++;
        if (obs_exc !== 1'b0) begin bad++; $display("FAIL sb_exc: got %b want 0", obs_exc); end
    endtask

    task automatic test_misaligned;
        logic [31:0] prev = exp_rdata;
        txn(6'b101011, 32'h6, 32'hDEAD_BEEF, 32'h0, 0);
        total++;
        if (obs_req_cyc !== 0 || obs_exc !== 1'b1 || obs_code !== 5'd5) begin
            bad++; $display("FAIL sw_ades: got req=%0d exc=%b code=%0d want req=0 exc=1 code=5", obs_req_cyc, obs_exc, obs_code);
        end
        txn(6'b100011, 32'h2, 32'h0, 32'h1234_5678, 0);
        total++;
        if (obs_req_cyc !== 0 || obs_exc !== 1'b1 || obs_code !== 5'd4) begin
            bad++; $display("FAIL lw_adel: got req=%0d exc=%b code=%0d want req=0 exc=1 code=4", obs_req_cyc, obs_exc, obs_code);
        end
        total++;
        if (obs_done_cyc !== 1 || obs_rdata !== prev) begin
            bad++; $display("FAIL adel_done_rdata: got cyc=%0d rdata=%h want cyc=1 rdata=%h", obs_done_cyc, obs_rdata, prev);
        end
    endtask

    task automatic test_unsupported;
        logic [31:0] prev = exp_rdata;
        txn(6'b100010, 32'h40, 32'h0, 32'hCAFE_F00D, 0);
        total++;
        if (obs_req_cyc !== 0 || obs_exc !== 1'b0 || obs_code !== 5'd0) begin
            bad++; $display("FAIL unsup: got req=%0d exc=%b code=%0d want req=0 exc=0 code=0", obs_req_cyc, obs_exc, obs_code);
        end
        total++;
        if (obs_rdata !== prev || obs_done_cyc !== 1) begin
            bad++; $display("FAIL unsup_rdata: got rdata=%h cyc=%0d want rdata=%h cyc=1", obs_rdata, obs_done_cyc, prev);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] prev = exp_rdata;
        txn(6'b100011, 32'h80, 32'h0, 32'h1111_2222, -1);
        total++;
        if (obs_req_cyc !== TO || obs_done_cyc !== TO + 1) begin
            bad++; $display("FAIL timeout_len: got req=%0d done=%0d want req=%0d done=%0d", obs_req_cyc, obs_done_cyc, TO, TO + 1);
        end
        total++;
        if (obs_exc !== 1'b1 || obs_code !== 5'd7 || obs_rdata !== prev) begin
            bad++; $display("FAIL timeout_dbe: got exc=%b code=%0d rdata=%h want exc=1 code=7 rdata=%h", obs_exc, obs_code, obs_rdata, prev);
        end
        txn(6'b100011, 32'h84, 32'h0, 32'h3333_4444, TO - 1);
        total++;
        if (obs_exc !== 1'b0 || obs_code !== 5'd0 || obs_rdata !== 32'h3333_4444 || obs_done_cyc !== TO + 1) begin
            bad++; $display("FAIL ack_at_limit: got exc=%b code=%0d rdata=%h cyc=%0d want exc=0 code=0 rdata=33334444 cyc=%0d",
                            obs_exc, obs_code, obs_rdata, obs_done_cyc, TO + 1);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done = 0;
        @(posedge clk); #1;
        mem_valid = 1; opcode = 6'b100011; addr = 32'h100; dm_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (dm_req !== 1'b1) begin bad++; $display("FAIL mid_req_before: got %b want 1", dm_req); end
        #2 reset = 0;
        #1;
        total++;
        if (dm_req !== 1'b0 || dm_be !== 4'h0 || dm_addr !== 32'h0 || rdata !== 32'h0) begin
            bad++; $display("FAIL mid_reset_async: got req=%b be=%h addr=%h rdata=%h want all zero", dm_req, dm_be, dm_addr, rdata);
        end
        repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
        mem_valid = 0;
        reset = 1;
        exp_rdata = 0;
        repeat (2) begin @(negedge clk); if (done) saw_done = 1; end
        total++;
        if (saw_done) begin bad++; $display("FAIL mid_no_done: got done=1 want no done"); end
        txn(6'b100011, 32'h200, 32'h0, 32'h1234_5678, 1);
        total++;
        if (obs_rdata !== 32'h1234_5678 || obs_exc !== 1'b0 || obs_done_cyc !== 3) begin
            bad++; $display("FAIL mid_recover: got rdata=%h exc=%b cyc=%0d want rdata=12345678 exc=0 cyc=3", obs_rdata, obs_exc, obs_done_cyc);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops [13] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                 6'b101000, 6'b101001, 6'b101011, 6'b100010, 6'b100110,
                                 6'b101010, 6'b101110, 6'b000000};
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op = ops[$urandom_range(12, 0)];
            txn(op, $urandom, $urandom, $urandom, int'($urandom_range(4, 0)) - 1);
            total++;
            if (obs_done_cyc !== exp_done_cyc || obs_req_cyc !== exp_req_cyc) begin
                bad++; $display("FAIL rnd_timing op=%b: got done=%0d req=%0d want done=%0d req=%0d",
                                op, obs_done_cyc, obs_req_cyc, exp_done_cyc, exp_req_cyc);
            end
            total++;
            if (obs_exc !== exp_exc || obs_code !== exp_code || obs_rdata !== exp_rdata) begin
                bad++; $display("FAIL rnd_result op=%b addr=%h: got exc=%b code=%0d rdata=%h want exc=%b code=%0d rdata=%h",
                                op, addr, obs_exc, obs_code, obs_rdata, exp_exc, exp_code, exp_rdata);
            end
            if (exp_access) begin
                total++;
                if (obs_we !== exp_we || obs_be !== exp_be || obs_addr !== exp_addr || (exp_we && obs_wd !== exp_wd)) begin
                    bad++; $display("FAIL rnd_bus op=%b: got we=%b be=%b addr=%h wd=%h want we=%b be=%b addr=%h wd=%h",
                                    op, obs_we, obs_be, obs_addr, obs_wd, exp_we, exp_be, exp_addr, exp_wd);
                end
            end
            total++;
            if (!obs_stall_ok || obs_after !== 6'b0) begin
                bad++; $display("FAIL rnd_stall_idle op=%b: got stall_ok=%b req/we/be=%b want 1 and 000000", op, obs_stall_ok, obs_after);
            end
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_lhu_wait;
        test_sb;
        test_misaligned;
        test_unsupported;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles dm_req may wait for dm_ack before a bus error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_valid  input  1  MEM-stage memory request, held high until done.
REQ-005 opcode  input  6  MIPS opcode of the request, stable while mem_valid.
REQ-006 addr  input  32  byte address, stable while mem_valid.
REQ-007 wdata  input  32  store data (rt), stable while mem_valid.
REQ-008 stall  output  1  pipeline freeze request.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  extended load result, valid with done, held until the next done.
REQ-011 exc  output  1  exception flag, valid with done.
REQ-012 exc_code  output  5  4=AdEL, 5=AdES, 7=DBE, 0=none.
REQ-013 dm_req  output  1  memory request, held until dm_ack or timeout.
REQ-014 dm_we  output  1  write enable, valid with dm_req.
REQ-015 dm_be  output  4  byte enables; bit i selects byte lane i.
REQ-016 dm_addr  output  32  word address {addr[31:2],2'b00}.
REQ-017 dm_wdata  output  32  lane-replicated store data.
REQ-018 dm_ack  input  1  memory accepted/finished the access this cycle.
REQ-019 dm_rdata  input  32  read word, valid with dm_ack.

Function
REQ-020 Supported opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
REQ-021 States IDLE, ACCESS, RESP; reset state IDLE.
REQ-022 IDLE, mem_valid and supported and aligned: latch opcode/addr/wdata and go to ACCESS; dm_req rises the next cycle.
REQ-023 Alignment rule: halfword ops need addr[0]=0; word ops need addr[1:0]=00; byte ops are always aligned.
REQ-024 IDLE, mem_valid with a misaligned load: go to RESP with exc=1 and exc_code=4; misaligned store: exc_code=5; no memory access in either case.
REQ-025 IDLE, mem_valid with an unsupported opcode: go to RESP with exc=0 and rdata unchanged; no memory access.
REQ-026 ACCESS: dm_req=1 and outputs driven from latched values; on dm_ack go to RESP and capture rdata for loads.
REQ-027 Timeout counter clears on entry to ACCESS and increments each cycle without dm_ack. When it reaches TIMEOUT-1 without ack: drop dm_req, go to RESP with exc=1, exc_code=7.
REQ-028 If dm_ack arrives in the same cycle as the timeout, the ack wins and there is no exception.
REQ-029 RESP: done=1 for exactly one cycle, then return to IDLE. A new request may be accepted in the following IDLE cycle.
REQ-030 stall = mem_valid & ~done (combinational).
REQ-031 Latency: mem_valid in cycle 0 and dm_ack in cycle 1 gives done in cycle 2; each additional wait cycle adds one.
REQ-032 Byte enables:
  - sb: lane addr[1:0].
  - sh: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - sw and all loads: 1111.
REQ-033 dm_wdata:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
REQ-034 Load extraction from dm_rdata:
  - lb/lbu: byte at lane addr[1:0], sign-/zero-extended to 32 bits.
  - lh/lhu: half at addr[1], sign-/zero-extended (lhu adds exactly 16 zero bits).
  - lw: full word.
REQ-035 dm_we=1 only for stores in ACCESS. dm_req, dm_we and dm_be are 0 outside ACCESS.

Reset
REQ-036 Asserting reset in any state forces IDLE immediately. It also zeroes every output except stall (rdata, exc, exc_code, done, dm_req, dm_we, dm_be, dm_addr, dm_wdata) and clears the timeout counter.
REQ-037 An access interrupted by reset is abandoned; no done is produced for it.

Verification
REQ-038 lb addr=0x1003, dm_rdata=0x80FF_1234, ack in 1st ACCESS cycle -> dm_be=1111, rdata=0xFFFF_FF80, done in cycle 2.
REQ-039 lhu addr=0x2002, dm_rdata=0x9ABC_0000, 3 wait cycles -> rdata=0x0000_9ABC, done in cycle 5, stall high cycles 0-4.
REQ-040 sb addr=0x10, wdata=0x55 -> dm_we=1, dm_be=0001, dm_wdata=0x5555_5555, dm_addr=0x10.
REQ-041 sw addr=0x6 -> no dm_req, done with exc=1, exc_code=5. lw addr=0x2 -> exc_code=4.
REQ-042 TIMEOUT=4 with dm_ack never asserted -> dm_req high for 4 cycles, then done with exc_code=7. Repeat with ack exactly at the 4th cycle -> no exception.
REQ-043 reset pulled low during ACCESS -> dm_req=0 and state IDLE immediately, no done. After release, a new request completes normally.
